// File: rtl/dart_scoreboard_if.sv
// Round-transfer bus between the dart scoring stage and dart_scoreboard.
// The master drives the scores and the round maximum. The slave returns in_ready.
interface dart_scoreboard_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] scores_in;
    logic [2:0]  max_in;

    modport master (output in_valid, output scores_in, output max_in, input in_ready);
    modport slave  (input in_valid, input scores_in, input max_in, output in_ready);
endinterface

// File: rtl/dart_scoreboard.sv
// dart_scoreboard: keeps the per-player totals over ROUNDS rounds, tracks the
// leader and the best round maximum, and flags game over.
// Optional feature: define DART_BULLSEYE_BONUS_EN to score a 7 as 10 points.
module dart_scoreboard #(
    parameter int unsigned ROUNDS  = 5,
    parameter int unsigned TOTAL_W = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    dart_scoreboard_if.slave       bus,
    output logic [4*TOTAL_W-1:0]   totals,
    output logic [3:0]             round,
    output logic [2:0]             best,
    output logic [1:0]             leader,
    output logic                   leader_tie,
    output logic                   game_over
);
    localparam int unsigned SUM_W = TOTAL_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [TOTAL_W-1:0]   r_tot [4];
    logic [3:0]           r_round;
    logic [2:0]           r_best;
    logic                 w_accept;
    logic [3:0]           w_addend  [4];
    logic [SUM_W-1:0]     w_sum     [4];
    logic [TOTAL_W-1:0]   w_tot_sat [4];
    logic [TOTAL_W-1:0]   w_top;
    logic [1:0]           w_lead;
    logic [2:0]           w_cnt;

    // A start in the same cycle drops the round.
    assign w_accept = bus.in_valid & bus.in_ready & ~start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs. A start in any state goes to PLAY.
    always_comb begin
        w_next       = r_state;
        bus.in_ready = 1'b0;
        game_over    = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_PLAY: begin
                bus.in_ready = 1'b1;
                if (w_accept && (r_round == 4'(ROUNDS - 1))) w_next = S_DONE;
            end
            S_DONE: game_over = 1'b1;
            default: w_next = S_IDLE;
        endcase
        if (start) w_next = S_PLAY;
    end

    // Saturating per-player adders. A score of 7 may be worth 10 points.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
`ifdef DART_BULLSEYE_BONUS_EN
            w_addend[i] = (bus.scores_in[3*i +: 3] == 3'd7) ? 4'd10 : {1'b0, bus.scores_in[3*i +: 3]};
`else
            w_addend[i] = {1'b0, bus.scores_in[3*i +: 3]};
`endif
            w_sum[i]     = {1'b0, r_tot[i]} + SUM_W'(w_addend[i]);
            w_tot_sat[i] = w_sum[i][TOTAL_W] ? '1 : w_sum[i][TOTAL_W-1:0];
        end
    end

    // Game state: totals, round count and best maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) r_tot[i] <= '0;
            r_round <= '0;
            r_best  <= '0;
        end else if (start) begin
            for (int unsigned i = 0; i < 4; i++) r_tot[i] <= '0;
            r_round <= '0;
            r_best  <= '0;
        end else if (w_accept) begin
            for (int unsigned i = 0; i < 4; i++) r_tot[i] <= w_tot_sat[i];
            r_round <= r_round + 4'd1;
            if (bus.max_in > r_best) r_best <= bus.max_in;
        end
    end

    // Leader: the first strictly larger total wins, so ties go to the lowest index.
    always_comb begin
        w_top  = r_tot[0];
        w_lead = '0;
        w_cnt  = '0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (r_tot[i] > w_top) begin
                w_top  = r_tot[i];
                w_lead = 2'(i);
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_tot[i] == w_top) w_cnt = w_cnt + 3'd1;
        end
    end

    // Output packing
    always_comb begin
        totals = '0;
        for (int unsigned i = 0; i < 4; i++) totals[i*TOTAL_W +: TOTAL_W] = r_tot[i];
    end

    assign round      = r_round;
    assign best       = r_best;
    assign leader     = w_lead;
    assign leader_tie = (w_cnt > 3'd1);
endmodule
